// File: rtl/led_pkg.sv
// Package shared by the LED frame scheduler slice.
// Contents:
//   - fsm_state_e      : scheduler FSM encoding (also visible on dbg_state)
//   - NUM_LEDS_DEFAULT : default frame width in led_state bits
//   - SRC_PWM, SRC_GOL : source indices of the two pattern generators
package led_pkg;

  localparam int NUM_LEDS_DEFAULT = 144;

  localparam int SRC_PWM = 0;
  localparam int SRC_GOL = 1;

  typedef enum logic [1:0] {
    S_KICK    = 2'd0,
    S_DISPLAY = 2'd1,
    S_WAIT    = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises and debounces a raw active-low push button.
// Ports:
//   clock       in  system clock
//   aclr_n      in  asynchronous active-low reset
//   btn_n       in  raw button, asynchronous, active-low, bouncy
//   press_pulse out 1-cycle pulse on each accepted press (debounced 1->0 edge)
// The debounced level only moves after DEBOUNCE_CYCLES consecutive samples that
// all differ from the current level; any sample equal to it restarts the count.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic aclr_n,
  input  logic btn_n,
  output logic press_pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Released level (1) is the reset value so no phantom press appears at reset.
  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      sync_1      <= 1'b1;
      sync_2      <= 1'b1;
      stable      <= 1'b1;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync_1      <= btn_n;
      sync_2      <= sync_1;
      press_pulse <= 1'b0;
      if (sync_2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // Accept the new level; the counter is cleared here so it never wraps.
        stable      <= sync_2;
        cnt         <= '0;
        press_pulse <= ~sync_2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_frame_scheduler.sv
// Owns the led_state bus feeding the charlieplex scanner.
// Ports:
//   clock        in   system clock
//   aclr_n       in   asynchronous active-low reset
//   toggle_btn_n in   raw toggle button (active-low, bouncy)
//   frame_done   in   1-cycle pulse at the end of each full scan
//   src_state    in   packed source frames, src i at [i*NUM_LEDS +: NUM_LEDS]
//   src_ack      in   1-cycle pulse per source: its frame is valid and stable
//   step_req     out  1-cycle pulse per source: compute the next frame
//   led_state    out  registered frame shown by the scanner
//   active_src   out  currently selected source
//   busy         out  high while waiting for the active source's ack
//   ack_error    out  sticky: an ack timeout occurred since reset
//   dbg_state    out  FSM state (fsm_state_e encoding)
// Handshake: step_req[i] and src_ack[i] are single-cycle pulses. A request is
// issued once per step; only an ack from the active source, seen while waiting,
// completes it and loads led_state. Acks at any other time or from any other
// source are dropped. If no ack arrives within ACK_TIMEOUT cycles the step is
// abandoned and the previous frame stays on the display.
module led_frame_scheduler
  import led_pkg::*;
#(
  parameter int NUM_LEDS        = NUM_LEDS_DEFAULT,
  parameter int NUM_SRC         = 2,
  parameter int FRAMES_PER_STEP = 8,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int ACK_TIMEOUT     = 4096
) (
  input  logic                        clock,
  input  logic                        aclr_n,
  input  logic                        toggle_btn_n,
  input  logic                        frame_done,
  input  logic [NUM_SRC*NUM_LEDS-1:0] src_state,
  input  logic [NUM_SRC-1:0]          src_ack,
  output logic [NUM_SRC-1:0]          step_req,
  output logic [NUM_LEDS-1:0]         led_state,
  output logic [$clog2(NUM_SRC)-1:0]  active_src,
  output logic                        busy,
  output logic                        ack_error,
  output logic [1:0]                  dbg_state
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int FC_W  = $clog2(FRAMES_PER_STEP + 1);
  localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ST_KICK    = S_KICK;
  localparam logic [1:0] ST_DISPLAY = S_DISPLAY;
  localparam logic [1:0] ST_WAIT    = S_WAIT;

  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_STEP - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [SRC_W-1:0] SRC_LAST = SRC_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0] REQ_ONE = {{(NUM_SRC-1){1'b0}}, 1'b1};

  logic [1:0]          state;
  logic [FC_W-1:0]     frame_cnt;
  logic [TO_W-1:0]     timeout_cnt;
  logic                toggle_pending;
  logic                toggle_service;
  logic                press_pulse;
  logic                ack_hit;
  logic [NUM_LEDS-1:0] sel_frame;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clock       (clock),
    .aclr_n      (aclr_n),
    .btn_n       (toggle_btn_n),
    .press_pulse (press_pulse)
  );

  assign ack_hit   = src_ack[active_src];
  assign sel_frame = src_state[int'(active_src)*NUM_LEDS +: NUM_LEDS];
  assign busy      = (state == ST_WAIT);
  assign dbg_state = state;

  // A switch is only ever taken on a frame boundary seen in S_DISPLAY.
  assign toggle_service = (state == ST_DISPLAY) && frame_done && toggle_pending;

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state          <= ST_KICK;
      frame_cnt      <= '0;
      timeout_cnt    <= '0;
      toggle_pending <= 1'b0;
      step_req       <= '0;
      led_state      <= '0;
      active_src     <= '0;
      ack_error      <= 1'b0;
    end else begin
      step_req <= '0;
      // A press landing on the service cycle survives for the next boundary;
      // extra presses before service collapse into the single pending flag.
      toggle_pending <= press_pulse | (toggle_pending & ~toggle_service);

      case (state)
        ST_KICK: begin
          step_req    <= REQ_ONE << active_src;
          timeout_cnt <= '0;
          state       <= ST_WAIT;
        end

        ST_DISPLAY: begin
          if (frame_done) begin
            if (toggle_pending) begin
              active_src <= (active_src == SRC_LAST) ? '0 : active_src + SRC_W'(1);
              frame_cnt  <= '0;
              state      <= ST_KICK;
            end else if (frame_cnt == FC_LAST) begin
              frame_cnt <= '0;
              state     <= ST_KICK;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end

        ST_WAIT: begin
          if (ack_hit) begin
            led_state <= sel_frame;
            state     <= ST_DISPLAY;
          end else if (timeout_cnt == TO_LAST) begin
            ack_error <= 1'b1;
            state     <= ST_DISPLAY;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end

        default: state <= ST_KICK;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Directed bench for led_frame_scheduler with short debounce/step/timeout values.
module tb_led_frame_scheduler;
  import led_pkg::*;

  localparam int NL  = 144;
  localparam int NS  = 2;
  localparam int FPS = 2;
  localparam int DBC = 4;
  localparam int ATO = 16;

  logic            clk;
  logic            aclr_n;
  logic            toggle_btn_n;
  logic            frame_done;
  logic [NS*NL-1:0] src_state;
  logic [NS-1:0]   src_ack;
  logic [NS-1:0]   step_req;
  logic [NL-1:0]   led_state;
  logic            active_src;
  logic            busy;
  logic            ack_error;
  logic [1:0]      dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int n_req0   = 0;
  int n_req1   = 0;
  int snap;
  logic [NL-1:0] exp_q[$];
  logic [NL-1:0] ones;

  led_frame_scheduler #(
    .NUM_LEDS        (NL),
    .NUM_SRC         (NS),
    .FRAMES_PER_STEP (FPS),
    .DEBOUNCE_CYCLES (DBC),
    .ACK_TIMEOUT     (ATO)
  ) dut (
    .clock        (clk),
    .aclr_n       (aclr_n),
    .toggle_btn_n (toggle_btn_n),
    .frame_done   (frame_done),
    .src_state    (src_state),
    .src_ack      (src_ack),
    .step_req     (step_req),
    .led_state    (led_state),
    .active_src   (active_src),
    .busy         (busy),
    .ack_error    (ack_error),
    .dbg_state    (dbg_state)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1);
  end

  always @(posedge clk) begin
    if (step_req[0]) n_req0++;
    if (step_req[1]) n_req1++;
  end

  task automatic check(input string tag, input logic [NL-1:0] got, input logic [NL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_frame;
    frame_done = 1'b1;
    tick;
    frame_done = 1'b0;
  endtask

  task automatic expect_step(input string tag, input logic [NS-1:0] exp);
    int n;
    n = 0;
    tick;
    while (step_req == '0 && n < 6) begin
      tick;
      n++;
    end
    check(tag, NL'(step_req), NL'(exp));
    check({tag, "_busy"}, NL'(busy), NL'(1));
  endtask

  task automatic do_ack(input int src, input logic [NL-1:0] val);
    src_state[src*NL +: NL] = val;
    src_ack = '0;
    src_ack[src] = 1'b1;
    exp_q.push_back(val);
    tick;
    src_ack = '0;
    check($sformatf("ack_frame_src%0d", src), led_state, exp_q.pop_front());
    check("busy_low_after_ack", NL'(busy), NL'(0));
  endtask

  initial begin
    ones = '1;
    aclr_n = 1'b0;
    toggle_btn_n = 1'b1;
    frame_done = 1'b0;
    src_state = '0;
    src_ack = '0;
    repeat (3) tick;

    // Reset state
    check("rst_led_state", led_state, NL'(0));
    check("rst_active_src", NL'(active_src), NL'(0));
    check("rst_step_req", NL'(step_req), NL'(0));
    check("rst_busy", NL'(busy), NL'(0));
    check("rst_ack_error", NL'(ack_error), NL'(0));
    check("rst_state", NL'(dbg_state), NL'(S_KICK));

    // 1: first step after reset, ack src0 with A5
    aclr_n = 1'b1;
    expect_step("t1_first_step", 2'b01);
    check("t1_led_before_ack", led_state, NL'(0));
    tick;
    check("t1_step_one_cycle", NL'(step_req), NL'(0));
    do_ack(0, NL'('hA5));
    check("t1_active_src", NL'(active_src), NL'(0));
    check("t1_state", NL'(dbg_state), NL'(S_DISPLAY));

    // 2: one step per FPS frames
    snap = n_req0;
    pulse_frame;
    tick;
    tick;
    check("t2_no_step_first", NL'(n_req0), NL'(snap));
    pulse_frame;
    expect_step("t2_step", 2'b01);
    do_ack(0, NL'('h3C));
    check("t2_one_step", NL'(n_req0), NL'(snap + 1));

    // 3: bouncy press, switch on next frame_done
    toggle_btn_n = 1'b1; tick;
    toggle_btn_n = 1'b0; tick;
    toggle_btn_n = 1'b1; tick;
    toggle_btn_n = 1'b0;
    repeat (10) tick;
    check("t3_no_switch_yet", NL'(active_src), NL'(0));
    toggle_btn_n = 1'b1;
    repeat (10) tick;
    pulse_frame;
    check("t3_switched", NL'(active_src), NL'(1));
    expect_step("t3_step_src1", 2'b10);
    do_ack(1, ones);

    // 4: ack timeout
    pulse_frame;
    pulse_frame;
    expect_step("t4_step", 2'b10);
    repeat (ATO - 1) tick;
    check("t4_still_busy", NL'(busy), NL'(1));
    check("t4_no_err_yet", NL'(ack_error), NL'(0));
    tick;
    check("t4_ack_error", NL'(ack_error), NL'(1));
    check("t4_busy_low", NL'(busy), NL'(0));
    check("t4_led_kept", led_state, ones);
    check("t4_state", NL'(dbg_state), NL'(S_DISPLAY));
    src_state[1*NL +: NL] = NL'('h77);
    src_ack = 2'b10;
    tick;
    src_ack = '0;
    tick;
    check("t4_stray_ack_led", led_state, ones);
    check("t4_err_sticky", NL'(ack_error), NL'(1));

    // 5: frame_done + press in S_WAIT, foreign acks ignored
    pulse_frame;
    pulse_frame;
    expect_step("t5_step", 2'b10);
    frame_done = 1'b1;
    toggle_btn_n = 1'b0;
    src_state[0 +: NL] = NL'('h11);
    src_ack = 2'b01;
    tick;
    frame_done = 1'b0;
    repeat (9) tick;
    src_ack = '0;
    check("t5_wait_busy", NL'(busy), NL'(1));
    check("t5_led_held", led_state, ones);
    toggle_btn_n = 1'b1;
    do_ack(1, NL'('h5A));
    check("t5_src_kept", NL'(active_src), NL'(1));
    snap = n_req0 + n_req1;
    repeat (10) tick;
    check("t5_no_early_switch", NL'(active_src), NL'(1));
    check("t5_no_step", NL'(n_req0 + n_req1), NL'(snap));
    pulse_frame;
    check("t5_deferred_switch", NL'(active_src), NL'(0));
    expect_step("t5_step_src0", 2'b01);
    check("t5_err_still", NL'(ack_error), NL'(1));

    // 6: reset mid-wait
    aclr_n = 1'b0;
    #1;
    check("t6_led_zero", led_state, NL'(0));
    check("t6_src_zero", NL'(active_src), NL'(0));
    check("t6_req_zero", NL'(step_req), NL'(0));
    check("t6_busy_zero", NL'(busy), NL'(0));
    check("t6_err_zero", NL'(ack_error), NL'(0));
    src_state[0 +: NL] = NL'('hEE);
    src_ack = 2'b01;
    tick;
    src_ack = '0;
    aclr_n = 1'b1;
    expect_step("t6_restep", 2'b01);
    check("t6_err_after", NL'(ack_error), NL'(0));
    check("t6_late_ack_ignored", led_state, NL'(0));
    tick;
    do_ack(0, NL'('hC3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
